store_buffer: RTL and testbench

- Sits between the pipeline MEM stage and the word-addressed data memory.
- Queues stores in a small FIFO and drains them to memory in cycles with no load; loads take priority.
- Detects load-after-store address hazards: the load stalls until the conflicting entries drain, or is forwarded when STORE_FORWARD_EN is compiled in.
- Provides a fence handshake that empties the buffer before the core proceeds.

---
 rtl/store_buffer_pkg.sv | 22 ++
 rtl/sb_addr_match.sv | 39 +++
 rtl/store_buffer.sv | 147 ++++++++++++++
 tb/tb_store_buffer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer.
package store_buffer_pkg;

  localparam int unsigned SB_ADDR_W = 9;
  localparam int unsigned SB_DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Entry field widths track the top-level defaults of DM_ADDRESS and DATA_W.
  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [2:0]           funct3;
  } sb_entry_t;

  typedef enum logic [0:0] {SB_RUN, SB_FENCE} sb_state_e;

endpackage

// File: rtl/sb_addr_match.sv
// Parallel load-address compare against every buffered store.
// With STORE_FORWARD_EN defined it also reports the youngest matching entry.
module sb_addr_match #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 9
) (
  input  logic [AW-1:0]                ld_addr,
  input  logic [DEPTH-1:0][AW-1:0]     entry_addrs,
  input  logic [DEPTH-1:0]             valid,
`ifdef STORE_FORWARD_EN
  input  logic [$clog2(DEPTH)-1:0]     head,
  output logic [$clog2(DEPTH)-1:0]     youngest,
`endif
  output logic [DEPTH-1:0]             hit
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = valid[i] && (entry_addrs[i] == ld_addr);
    end
  end

`ifdef STORE_FORWARD_EN
  localparam int unsigned PW = $clog2(DEPTH);

  // Walk from oldest to newest; the last hit seen is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    youngest = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + k[PW-1:0];
      if (hit[idx]) youngest = idx;
    end
  end
`endif

endmodule

// File: rtl/store_buffer.sv
// Store buffer between MEM stage and data memory: FIFO of stores drained in load-free cycles.
// Optional load forwarding from a matching full-word store is enabled by STORE_FORWARD_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = SB_ADDR_W,
  parameter int unsigned DATA_W     = SB_DATA_W,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [DM_ADDRESS-1:0] st_addr,
  input  logic [DATA_W-1:0]     st_data,
  input  logic [2:0]            st_funct3,
  input  logic                  ld_valid,
  input  logic [DM_ADDRESS-1:0] ld_addr,
  input  logic [2:0]            ld_funct3,
  output logic                  ld_stall,
  output logic [DATA_W-1:0]     ld_data,
  input  logic                  fence_req,
  output logic                  fence_done,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_entry_t                       entries_q [DEPTH];
  logic [DEPTH-1:0]                valid_q;
  logic [PW-1:0]                   head_q, tail_q;
  logic [CW-1:0]                   count_q, count_d;
  sb_state_e                       state_q;
  logic                            fence_done_q;

  logic [DEPTH-1:0][DM_ADDRESS-1:0] entry_addrs;
  logic [DEPTH-1:0]                hit;
  logic                            hazard, push, drain;
  sb_entry_t                       head_entry;
`ifdef STORE_FORWARD_EN
  logic [PW-1:0]                   youngest;
  logic                            fwd;
`endif

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_addrs[i] = entries_q[i].addr;
  end

  sb_addr_match #(
    .DEPTH (DEPTH),
    .AW    (DM_ADDRESS)
  ) u_match (
    .ld_addr     (ld_addr),
    .entry_addrs (entry_addrs),
    .valid       (valid_q),
`ifdef STORE_FORWARD_EN
    .head        (head_q),
    .youngest    (youngest),
`endif
    .hit         (hit)
  );

  always_comb begin
    head_entry = entries_q[head_q];
    hazard     = ld_valid && (|hit);
    st_ready   = (state_q == SB_RUN) && (count_q < CW'(DEPTH));
    push       = st_valid && st_ready;
    mem_read   = ld_valid && !hazard;
    // A hazard implies a valid entry, so the head always exists when draining for it.
    drain      = (count_q != '0) && (!ld_valid || hazard);
    mem_write  = drain;
    ld_stall   = hazard;
    ld_data    = '0;
    mem_a      = '0;
    mem_wd     = '0;
    mem_funct3 = '0;
    if (mem_read) begin
      mem_a      = ld_addr;
      mem_funct3 = ld_funct3;
      ld_data    = mem_rd;
    end else if (drain) begin
      mem_a      = head_entry.addr;
      mem_wd     = head_entry.data;
      mem_funct3 = head_entry.funct3;
    end
`ifdef STORE_FORWARD_EN
    fwd = hazard && (ld_funct3 == F3_W) && (entries_q[youngest].funct3 == F3_W);
    if (fwd) begin
      ld_stall = 1'b0;
      ld_data  = entries_q[youngest].data;
    end
`endif
    count_d = count_q + CW'(push) - CW'(drain);
  end

  assign fence_done = fence_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      valid_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      state_q      <= SB_RUN;
      fence_done_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        entries_q[tail_q] <= '{addr: st_addr, data: st_data, funct3: st_funct3};
        valid_q[tail_q]   <= 1'b1;
        tail_q            <= tail_q + 1'b1;
      end
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      // fence_done is high exactly in the FENCE cycle that finds the buffer empty.
      case (state_q)
        SB_RUN: begin
          if (fence_req) begin
            state_q      <= SB_FENCE;
            fence_done_q <= (count_d == '0);
          end
        end
        SB_FENCE: begin
          if (count_q == '0) begin
            state_q      <= SB_RUN;
            fence_done_q <= 1'b0;
          end else begin
            fence_done_q <= (count_d == '0);
          end
        end
        default: begin
          state_q      <= SB_RUN;
          fence_done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: architectural memory model plus write/load expectation queues.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          st_valid = 1'b0, st_ready;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic [2:0]    st_funct3 = '0;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [2:0]    ld_funct3 = '0;
  logic          ld_stall;
  logic [DW-1:0] ld_data;
  logic          fence_req = 1'b0, fence_done;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [2:0]    mem_funct3;
  logic [DW-1:0] mem_rd;

  always #5 clk = ~clk;

  store_buffer #(.DM_ADDRESS(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_funct3(st_funct3), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_funct3(ld_funct3), .ld_stall(ld_stall), .ld_data(ld_data), .fence_req(fence_req),
    .fence_done(fence_done), .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_funct3(mem_funct3), .mem_rd(mem_rd)
  );

  function automatic logic [31:0] wr_word(input logic [31:0] old, input logic [31:0] d,
                                          input logic [2:0] f);
    case (f)
      F3_B:    return {old[31:8], d[7:0]};
      F3_H:    return {old[31:16], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] w, input logic [2:0] f);
    case (f)
      F3_B:    return {{24{w[7]}}, w[7:0]};
      F3_H:    return {{16{w[15]}}, w[15:0]};
      F3_BU:   return {24'b0, w[7:0]};
      F3_HU:   return {16'b0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // phys_mem is what the DUT writes; arch_mem is program-order truth.
  logic [31:0] phys_mem [512];
  logic [31:0] arch_mem [512];
  assign mem_rd = rd_word(phys_mem[mem_a], mem_funct3);

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    f;
  } wr_t;
  wr_t         exp_wr[$];
  logic [31:0] exp_ld[$];
  wr_t         mon_e;
  logic [31:0] mon_l;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("one_access_per_cycle", {31'b0, mem_read & mem_write}, 32'd0);
      if (mem_write) begin
        if (exp_wr.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious_write: got write to %0h, expected no write", mem_a);
        end else begin
          mon_e = exp_wr.pop_front();
          check("drain_addr", {23'b0, mem_a}, {23'b0, mon_e.a});
          check("drain_data", mem_wd, mon_e.d);
          check("drain_funct3", {29'b0, mem_funct3}, {29'b0, mon_e.f});
        end
      end
      if (ld_valid && !ld_stall) begin
        if (exp_ld.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious_load: got load result %0h, expected none", ld_data);
        end else begin
          mon_l = exp_ld.pop_front();
          check("load_data", ld_data, mon_l);
        end
      end
    end
  end

  logic          s_st_ready, s_ld_stall, s_mem_read, s_mem_write, s_fence_done;
  logic [31:0]   s_ld_data, s_mem_wd;
  logic [AW-1:0] s_mem_a;
  logic [2:0]    s_mem_f3;
  bit            ld_pending = 1'b0;

  // One clock cycle: drive after the edge, sample at negedge+1, apply memory write at the edge.
  task automatic step(input bit sv, input logic [AW-1:0] sa, input logic [31:0] sd,
                      input logic [2:0] sf, input bit lv, input logic [AW-1:0] la,
                      input logic [2:0] lf, input bit fr, input bit r);
    rst = r; st_valid = sv; st_addr = sa; st_data = sd; st_funct3 = sf;
    ld_valid = lv; ld_addr = la; ld_funct3 = lf; fence_req = fr;
    if (lv && !ld_pending && !r) exp_ld.push_back(rd_word(arch_mem[la], lf));
    @(negedge clk); #1;
    s_st_ready = st_ready; s_ld_stall = ld_stall; s_mem_read = mem_read;
    s_mem_write = mem_write; s_fence_done = fence_done; s_ld_data = ld_data;
    s_mem_a = mem_a; s_mem_wd = mem_wd; s_mem_f3 = mem_funct3;
    if (!r) begin
      ld_pending = lv && s_ld_stall;
      if (sv && s_st_ready) begin
        exp_wr.push_back('{sa, sd, sf});
        arch_mem[sa] = wr_word(arch_mem[sa], sd, sf);
      end
    end
    @(posedge clk);
    if (s_mem_write) phys_mem[s_mem_a] = wr_word(phys_mem[s_mem_a], s_mem_wd, s_mem_f3);
    if (r) begin
      exp_wr.delete(); exp_ld.delete(); ld_pending = 1'b0;
      arch_mem = phys_mem;
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, '0, F3_B, 0, '0, F3_B, 0, 0);
  endtask

  task automatic fence_cycle(input bit fr);
    step(0, '0, '0, F3_B, 0, '0, F3_B, fr, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  logic [2:0] ld_f3_tab [5];
  logic [2:0] st_f3_tab [3];

  initial begin
    int drains, pulses, done_cyc, writes, stall_run;
    bit seen, fence_on, sv, lv;
    logic [AW-1:0] sa, la;
    logic [2:0] sf, lf;
    int unsigned r;

    ld_f3_tab = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    st_f3_tab = '{F3_B, F3_H, F3_W};
    for (int i = 0; i < 512; i++) phys_mem[i] = $urandom;
    arch_mem = phys_mem;
    step(0, '0, '0, F3_B, 0, '0, F3_B, 0, 1);
    step(0, '0, '0, F3_B, 0, '0, F3_B, 0, 1);

    // Reset state
    idle(1);
    check("rst_st_ready", {31'b0, s_st_ready}, 32'd1);
    check("rst_mem_write", {31'b0, s_mem_write}, 32'd0);
    check("rst_mem_read", {31'b0, s_mem_read}, 32'd0);
    check("rst_ld_stall", {31'b0, s_ld_stall}, 32'd0);
    check("rst_ld_data", s_ld_data, 32'd0);
    check("rst_fence_done", {31'b0, s_fence_done}, 32'd0);

    // Single SW drains one cycle after acceptance
    step(1, 9'd5, 32'h12345678, F3_W, 0, '0, F3_B, 0, 0);
    check("sw_no_same_cycle_drain", {31'b0, s_mem_write}, 32'd0);
    idle(1);
    check("sw_drain_next", {31'b0, s_mem_write}, 32'd1);
    check("sw_drain_addr", {23'b0, s_mem_a}, 32'd5);
    check("sw_drain_data", s_mem_wd, 32'h12345678);
    idle(1);
    check("sw_empty_after", {31'b0, s_mem_write}, 32'd0);

    // Fill with loads every cycle, then drain in order
    for (int i = 0; i < 4; i++) begin
      step(1, AW'(i + 1), $urandom, F3_W, 1, 9'd100, F3_W, 0, 0);
      check("fill_no_drain", {31'b0, s_mem_write}, 32'd0);
      check("fill_no_stall", {31'b0, s_ld_stall}, 32'd0);
    end
    step(1, 9'd50, 32'hDEAD0000, F3_W, 1, 9'd100, F3_W, 0, 0);
    check("full_st_ready", {31'b0, s_st_ready}, 32'd0);
    check("full_load_no_drain", {31'b0, s_mem_write}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("drain_order", {23'b0, s_mem_a}, 32'(i + 1));
    end
    idle(1);
    check("fill_empty_after", {31'b0, s_mem_write}, 32'd0);

    // SB then LB to the same word: one stall, then sign-extended data from memory
    step(1, 9'd7, 32'h000000AB, F3_B, 0, '0, F3_B, 0, 0);
    step(0, '0, '0, F3_B, 1, 9'd7, F3_B, 0, 0);
    check("lb_hazard_stall", {31'b0, s_ld_stall}, 32'd1);
    check("lb_hazard_drain", {31'b0, s_mem_write}, 32'd1);
    step(0, '0, '0, F3_B, 1, 9'd7, F3_B, 0, 0);
    check("lb_after_stall", {31'b0, s_ld_stall}, 32'd0);
    check("lb_data", s_ld_data, 32'hFFFFFFAB);

    // SW then LW to the same word
    step(1, 9'd9, 32'hCAFEF00D, F3_W, 0, '0, F3_B, 0, 0);
    step(0, '0, '0, F3_B, 1, 9'd9, F3_W, 0, 0);
`ifdef STORE_FORWARD_EN
    check("fwd_no_stall", {31'b0, s_ld_stall}, 32'd0);
    check("fwd_data", s_ld_data, 32'hCAFEF00D);
    check("fwd_no_mem_read", {31'b0, s_mem_read}, 32'd0);
    check("fwd_head_drains", {31'b0, s_mem_write}, 32'd1);
`else
    check("lw_hazard_stall", {31'b0, s_ld_stall}, 32'd1);
    step(0, '0, '0, F3_B, 1, 9'd9, F3_W, 0, 0);
    check("lw_after_stall", {31'b0, s_ld_stall}, 32'd0);
    check("lw_data", s_ld_data, 32'hCAFEF00D);
`endif
    idle(2);

    // Fence with three buffered entries
    for (int i = 0; i < 3; i++) step(1, AW'(20 + i), $urandom, F3_W, 1, 9'd200, F3_W, 0, 0);
    drains = 0; pulses = 0; done_cyc = -1; seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      fence_cycle(!seen);
      if (s_mem_write) drains++;
      if (s_fence_done) begin
        pulses++;
        if (!seen) done_cyc = c;
        seen = 1'b1;
      end
      if (c == 1) check("fence_st_ready", {31'b0, s_st_ready}, 32'd0);
    end
    check("fence_drains", drains, 32'd3);
    check("fence_pulses", pulses, 32'd1);
    check("fence_done_cycle", done_cyc, 32'd3);
    fence_cycle(1);
    check("fence_empty_first", {31'b0, s_fence_done}, 32'd0);
    fence_cycle(1);
    check("fence_empty_done", {31'b0, s_fence_done}, 32'd1);
    fence_cycle(0);
    check("fence_empty_after", {31'b0, s_fence_done}, 32'd0);

    // Reset in the middle of draining two entries
    for (int i = 0; i < 2; i++) step(1, AW'(30 + i), $urandom, F3_W, 1, 9'd200, F3_W, 0, 0);
    step(0, '0, '0, F3_B, 0, '0, F3_B, 0, 1);
    idle(1);
    check("rst_mid_no_write", {31'b0, s_mem_write}, 32'd0);
    check("rst_mid_st_ready", {31'b0, s_st_ready}, 32'd1);
    writes = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (s_mem_write) writes++;
    end
    check("rst_mid_no_more_writes", writes, 32'd0);

    // Randomized traffic against the architectural model
    fence_on = 1'b0; stall_run = 0; la = '0; lf = F3_W;
    for (int c = 0; c < 3000; c++) begin
      sv = 1'b0; lv = 1'b0; sa = '0; sf = F3_W; sd_gen: begin end
      if (ld_pending) begin
        lv = 1'b1;
      end else begin
        r  = $urandom_range(0, 3);
        lv = (r == 1) || (r == 2);
        sv = (r == 0) || (r == 2);
        la = AW'($urandom_range(0, 7));
        lf = ld_f3_tab[$urandom_range(0, 4)];
        sa = AW'($urandom_range(0, 7));
        sf = st_f3_tab[$urandom_range(0, 2)];
        if (lv && sv && sa == la) sa = la ^ 9'd1;
      end
      if (!fence_on && $urandom_range(0, 49) == 0) fence_on = 1'b1;
      step(sv, sa, $urandom, sf, lv, la, lf, fence_on, 0);
      if (s_fence_done) fence_on = 1'b0;
      stall_run = ld_pending ? stall_run + 1 : 0;
      if (stall_run > DEPTH) begin
        check("stall_bound", stall_run, DEPTH);
        break;
      end
    end

    // Empty out and compare memory contents
    for (int i = 0; i < 12 && exp_wr.size() != 0; i++) fence_cycle(0);
    check("final_wr_queue", exp_wr.size(), 32'd0);
    check("final_ld_queue", exp_ld.size(), 32'd0);
    for (int i = 0; i < 8; i++) check("final_mem", phys_mem[i], arch_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
